// File: rtl/simple_cpu_v2.sv
// Parametrised multi-cycle core: one instruction at a time over valid/ready,
// register file, resettable data memory, register/immediate ALU with Z/C flags.
module simple_cpu_v2 #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20,
  parameter int REG_COUNT   = 4,
  localparam int RB         = $clog2(REG_COUNT),
  localparam int IMM_W      = INSTR_WIDTH - 6 - 3 * RB
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   flag_z,
  output logic                   flag_c,
  input  logic [RB-1:0]          dbg_reg_sel,
  output logic [DATA_WIDTH-1:0]  dbg_reg_data,
  input  logic [ADDR_BITS-1:0]   dbg_mem_addr,
  output logic [DATA_WIDTH-1:0]  dbg_mem_data
);

  localparam int MEM_WORDS = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [1:0] {
    C_ALUI  = 2'b00,
    C_ALUR  = 2'b01,
    C_LOAD  = 2'b10,
    C_STORE = 2'b11
  } class_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] rf   [REG_COUNT];
  logic [DATA_WIDTH-1:0] dmem [MEM_WORDS];

  logic [INSTR_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0]  op_a, op_b, st_data, res_q;
  logic                   carry_q;
  logic [ADDR_BITS-1:0]   addr_q;

  // Fields of the latched instruction, MSB first.
  class_t           cls;
  logic [RB-1:0]    x1, x2, x3;
  logic [IMM_W-1:0] imm;
  logic [3:0]       funct;

  assign cls   = class_t'(instr_q[INSTR_WIDTH-1 -: 2]);
  assign x1    = instr_q[INSTR_WIDTH-3 -: RB];
  assign x2    = instr_q[INSTR_WIDTH-3-RB -: RB];
  assign x3    = instr_q[INSTR_WIDTH-3-2*RB -: RB];
  assign imm   = instr_q[IMM_W+3:4];
  assign funct = instr_q[3:0];

  logic                  is_alu, illegal;
  logic [DATA_WIDTH-1:0] imm_ext;

  assign is_alu  = (cls == C_ALUI) || (cls == C_ALUR);
  assign illegal = is_alu && (funct > 4'd4);
  assign imm_ext = DATA_WIDTH'(imm);

  // ALU: the extra top bit of the widened add/sub is carry-out / borrow.
  logic [DATA_WIDTH:0]   sum_w, diff_w;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;
  logic [ADDR_BITS-1:0]  addr_calc;

  assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_w = {1'b0, op_a} - {1'b0, op_b};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (funct)
      4'd0: begin
        alu_res   = sum_w[DATA_WIDTH-1:0];
        alu_carry = sum_w[DATA_WIDTH];
      end
      4'd1: begin
        alu_res   = diff_w[DATA_WIDTH-1:0];
        alu_carry = diff_w[DATA_WIDTH];
      end
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      default: ;
    endcase
  end

  // Address arithmetic is done directly in ADDR_BITS, which is the required modulo.
  assign addr_calc = ADDR_BITS'(op_a) + ADDR_BITS'(imm);

  // Next-state and handshake/status decode.
  logic ready_c, done_c, err_c;

  always_comb begin
    state_n = state;
    ready_c = 1'b0;
    done_c  = 1'b0;
    err_c   = 1'b0;
    case (state)
      S_IDLE: begin
        ready_c = 1'b1;
        if (instr_valid) state_n = S_DECODE;
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        if (!is_alu) begin
          state_n = S_MEM;
        end else if (illegal) begin
          done_c  = 1'b1;
          err_c   = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_WB;
        end
      end
      S_MEM: begin
        if (cls == C_STORE) begin
          done_c  = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_WB;
        end
      end
      S_WB: begin
        done_c  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Status outputs are forced low while reset is held, even mid-instruction.
  assign instr_ready = ready_c & ~rst;
  assign busy        = (state != S_IDLE) & ~rst;
  assign done        = done_c & ~rst;
  assign err         = err_c & ~rst;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      instr_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
      st_data <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      addr_q  <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= DATA_WIDTH'(i);
      // NOTE: data memory has an architectural reset value, so it is built
      // from flops and cleared here rather than mapped to a RAM macro.
      for (int i = 0; i < MEM_WORDS; i++) dmem[i] <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (instr_valid) instr_q <= instruction;
        end
        S_DECODE: begin
          op_a    <= rf[x2];
          op_b    <= (cls == C_ALUI) ? imm_ext : rf[x3];
          st_data <= rf[x1];
        end
        S_EXEC: begin
          res_q   <= alu_res;
          carry_q <= alu_carry;
          addr_q  <= addr_calc;
        end
        S_MEM: begin
          if (cls == C_STORE) dmem[addr_q] <= st_data;
          else                res_q        <= dmem[addr_q];
        end
        S_WB: begin
          rf[x1] <= res_q;
          if (is_alu) begin
            flag_z <= (res_q == '0);
            flag_c <= carry_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_reg_data = rf[dbg_reg_sel];
  assign dbg_mem_data = dmem[dbg_mem_addr];

endmodule
